mux_rr_arbiter: RTL

- Round-robin arbiter that shares the 4:1 single-bit multiplexer between four requesters.
- Each requester drives one mux data input (in0..in3).
- The block grants one requester at a time and drives the mux address lines so the mux output carries the granted requester's data.
- It sits directly in front of the mux select pins. A grant is held while the owner keeps requesting, up to a bounded hold time.

---
 rtl/mux_rr_arbiter_pkg.sv | 29 ++
 rtl/mux_rr_arbiter_picker.sv | 28 ++
 rtl/mux_rr_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and one-hot/index helpers for the
// round-robin mux arbiter and its bench.
package mux_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx2oh(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_picker.sv
// Combinational rotating search: checks start+1 .. start+3, then start
// itself last unless excluded.
module rr_priority_picker
    import mux_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    input  logic               exclude_start,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = start + IDX_W'(k);
            if (!found && req[cand] && !(k == NUM_REQ && exclude_start)) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 mux, with a
// bounded hold time per grant and zero-gap handover.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               address0,
    output logic               address1,
    output logic               busy
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [IDX_W-1:0]   last_owner, last_owner_nx;
    logic [NUM_REQ-1:0] grant_nx;
    logic [IDX_W-1:0]   addr, addr_nx;

    logic               found;
    logic [IDX_W-1:0]   winner;
    logic               owner_req;

    assign owner_req = req[last_owner];

    // Owner is excluded only when it has dropped its request; on hold
    // expiry it stays eligible in the last slot.
    rr_priority_picker u_picker (
        .req           (req),
        .start         (last_owner),
        .exclude_start ((state == GRANTED) && !owner_req),
        .found         (found),
        .winner        (winner)
    );

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_owner_nx = last_owner;
        grant_nx      = grant;
        addr_nx       = addr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx      = GRANTED;
                    cnt_nx        = '0;
                    last_owner_nx = winner;
                    grant_nx      = idx2oh(winner);
                    addr_nx       = winner;
                end
            end
            GRANTED: begin
                if (owner_req && cnt != CNT_LAST) begin
                    cnt_nx = cnt + 1'b1;
                end else if (found) begin
                    cnt_nx        = '0;
                    last_owner_nx = winner;
                    grant_nx      = idx2oh(winner);
                    addr_nx       = winner;
                end else begin
                    // Address left alone so the mux select stays stable.
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    grant_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
            grant      <= '0;
            addr       <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_owner <= last_owner_nx;
            grant      <= grant_nx;
            addr       <= addr_nx;
        end
    end

    assign address0 = addr[0];
    assign address1 = addr[1];
    assign busy     = |grant;

endmodule
